// File: rtl/jtdd_rom_arb.sv
// Three-way ROM arbiter: main, sound and MCU each own a one-entry cache,
// and misses share a single SDRAM read port through a round-robin grant.
module jtdd_rom_arb #(
    parameter int          MAIN_AW     = 18,
    parameter int          SND_AW      = 15,
    parameter int          MCU_AW      = 14,
    parameter logic [21:0] MAIN_OFFSET = 22'h00_0000,
    parameter logic [21:0] SND_OFFSET  = 22'h04_0000,
    parameter logic [21:0] MCU_OFFSET  = 22'h04_8000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               main_cs,
    input  logic [MAIN_AW-1:0] main_addr,
    output logic [7:0]         main_data,
    output logic               main_ok,
    input  logic               snd_cs,
    input  logic [SND_AW-1:0]  snd_addr,
    output logic [7:0]         snd_data,
    output logic               snd_ok,
    input  logic               mcu_cs,
    input  logic [MCU_AW-1:0]  mcu_addr,
    output logic [7:0]         mcu_data,
    output logic               mcu_ok,
    output logic               sdram_req,
    output logic [21:0]        sdram_addr,
    input  logic               sdram_ack,
    input  logic               sdram_rdy,
    input  logic [7:0]         sdram_data
);

    localparam int TAG_W = (MAIN_AW > SND_AW) ? ((MAIN_AW > MCU_AW) ? MAIN_AW : MCU_AW)
                                              : ((SND_AW  > MCU_AW) ? SND_AW  : MCU_AW);

    localparam logic [1:0] SEL_MAIN = 2'd0;
    localparam logic [1:0] SEL_SND  = 2'd1;
    localparam logic [1:0] SEL_MCU  = 2'd2;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

    state_t             r_state, w_state_nx;
    logic               r_req, w_req_nx;
    logic [21:0]        r_addr, w_addr_nx;
    logic [1:0]         r_last, w_last_nx;
    logic [TAG_W-1:0]   r_pend, w_pend_nx;
    logic               w_fill;
    logic [1:0]         w_sel;
    logic [2:0]         w_miss;

    logic [MAIN_AW-1:0] r_main_tag;
    logic [SND_AW-1:0]  r_snd_tag;
    logic [MCU_AW-1:0]  r_mcu_tag;
    logic [7:0]         r_main_data, r_snd_data, r_mcu_data;
    logic               r_main_valid, r_snd_valid, r_mcu_valid;

    assign main_ok    = main_cs & r_main_valid & (r_main_tag == main_addr);
    assign snd_ok     = snd_cs  & r_snd_valid  & (r_snd_tag  == snd_addr);
    assign mcu_ok     = mcu_cs  & r_mcu_valid  & (r_mcu_tag  == mcu_addr);
    assign main_data  = r_main_data;
    assign snd_data   = r_snd_data;
    assign mcu_data   = r_mcu_data;
    assign sdram_req  = r_req;
    assign sdram_addr = r_addr;

    assign w_miss = {mcu_cs & ~mcu_ok, snd_cs & ~snd_ok, main_cs & ~main_ok};

    // Round-robin: scan from the requester after r_last; the nearest miss wins.
    always_comb begin
        w_sel = r_last;
        for (int k = 3; k >= 1; k--) begin
            int idx;
            idx = (int'(r_last) + k) % 3;
            if (w_miss[idx]) w_sel = 2'(idx);
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path infers a latch.
        w_state_nx = r_state;
        w_req_nx   = r_req;
        w_addr_nx  = r_addr;
        w_last_nx  = r_last;
        w_pend_nx  = r_pend;
        w_fill     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_miss) begin
                    w_last_nx  = w_sel;
                    w_req_nx   = 1'b1;
                    w_state_nx = WAIT_ACK;
                    case (w_sel)
                        SEL_MAIN: begin
                            w_pend_nx = TAG_W'(main_addr);
                            w_addr_nx = MAIN_OFFSET + 22'(main_addr);
                        end
                        SEL_SND: begin
                            w_pend_nx = TAG_W'(snd_addr);
                            w_addr_nx = SND_OFFSET + 22'(snd_addr);
                        end
                        default: begin
                            w_pend_nx = TAG_W'(mcu_addr);
                            w_addr_nx = MCU_OFFSET + 22'(mcu_addr);
                        end
                    endcase
                end
            end
            WAIT_ACK: begin
                if (sdram_ack) begin
                    w_req_nx   = 1'b0;
                    w_state_nx = WAIT_DATA;
                end
            end
            default: begin
                if (sdram_rdy) begin
                    w_fill     = 1'b1;
                    w_state_nx = IDLE;
                end
            end
        endcase
    end

    // NOTE: the cache entries are plain flops, so reset clears them along with the valid flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_last       <= SEL_MCU;
            r_pend       <= '0;
            r_main_tag   <= '0;
            r_snd_tag    <= '0;
            r_mcu_tag    <= '0;
            r_main_data  <= '0;
            r_snd_data   <= '0;
            r_mcu_data   <= '0;
            r_main_valid <= 1'b0;
            r_snd_valid  <= 1'b0;
            r_mcu_valid  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_req   <= w_req_nx;
            r_addr  <= w_addr_nx;
            r_last  <= w_last_nx;
            r_pend  <= w_pend_nx;
            if (w_fill) begin
                case (r_last)
                    SEL_MAIN: begin
                        r_main_tag   <= r_pend[MAIN_AW-1:0];
                        r_main_data  <= sdram_data;
                        r_main_valid <= 1'b1;
                    end
                    SEL_SND: begin
                        r_snd_tag    <= r_pend[SND_AW-1:0];
                        r_snd_data   <= sdram_data;
                        r_snd_valid  <= 1'b1;
                    end
                    default: begin
                        r_mcu_tag    <= r_pend[MCU_AW-1:0];
                        r_mcu_data   <= sdram_data;
                        r_mcu_valid  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
